// File: rtl/alaw_pkg.sv
// Shared constants and FSM state type for the A-law encode arbiter.
package alaw_pkg;

  localparam int unsigned SAMPLE_W = 13;  // {sign, 12-bit magnitude}
  localparam int unsigned MAG_W    = 12;
  localparam int unsigned ALAW_W   = 8;   // {sign, segment, mantissa}
  localparam int unsigned SEG_W    = 3;
  localparam int unsigned MANT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CODE  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alaw_coder.sv
// Combinational A-law encoder: 13-bit sign-magnitude sample -> 8-bit A-law byte.
// Ports:
//   sample  in  SAMPLE_W  bit 12 sign, bits 11:0 magnitude
//   alaw_c  out ALAW_W    {sign, 3-bit segment, 4-bit mantissa}, combinational
module alaw_coder
  import alaw_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample,
  output logic [ALAW_W-1:0]   alaw_c
);

  logic [MAG_W-1:0]  mag;
  logic [SEG_W-1:0]  seg;
  logic [MANT_W-1:0] mant;

  // Segment = position of the highest set bit in mag[11:5]; bit 5 alone and zero both
  // select the bits 4:1 mantissa window.
  always_comb begin
    mag  = sample[MAG_W-1:0];
    seg  = '0;
    mant = '0;
    for (int s = 1; s < 8; s++) begin
      if (mag[4+s]) seg = SEG_W'(s);
    end
    case (seg)
      3'd2:    mant = mag[5:2];
      3'd3:    mant = mag[6:3];
      3'd4:    mant = mag[7:4];
      3'd5:    mant = mag[8:5];
      3'd6:    mant = mag[9:6];
      3'd7:    mant = mag[10:7];
      default: mant = mag[4:1];
    endcase
    alaw_c = {sample[SAMPLE_W-1], seg, mant};
  end

endmodule

// File: rtl/alaw_encode_arbiter.sv
// Round-robin arbiter sharing one A-law encoder between N_CH linear-PCM requesters.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    in  N_CH           per-channel sample valid
//   req_sample   in  SAMPLE_W*N_CH  channel i at bits [13i+12:13i]
//   req_ready    out N_CH           one-hot grant, combinational (IDLE only)
//   out_valid    out 1              encoded byte valid
//   out_ready    in  1              sink accepts byte
//   out_alaw     out ALAW_W         encoded byte
//   out_ch       out CH_W           source channel of out_alaw
//   conv_cnt     out CNT_W          completed output handshakes (wrapping)
module alaw_encode_arbiter
  import alaw_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CH_W  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          req_valid,
  input  logic [SAMPLE_W*N_CH-1:0] req_sample,
  output logic [N_CH-1:0]          req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ALAW_W-1:0]        out_alaw,
  output logic [CH_W-1:0]          out_ch,
  output logic [CNT_W-1:0]         conv_cnt
);

  arb_state_t          state_q, state_d;
  logic [CH_W-1:0]     ptr_q;
  logic [SAMPLE_W-1:0] sample_q;
  logic [CH_W-1:0]     ch_q;
  logic                grant_any;
  logic [CH_W-1:0]     grant_idx;
  logic                load_in, load_out, done;
  logic [ALAW_W-1:0]   alaw_c;
  int unsigned         idx;

  alaw_coder u_coder (
    .sample (sample_q),
    .alaw_c (alaw_c)
  );

  // Priority search upward from ptr+1, wrapping past N_CH-1 to 0.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int i = 0; i < int'(N_CH); i++) begin
      idx = (32'(ptr_q) + 32'(i) + 32'd1) % N_CH;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = CH_W'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = CODE;
      CODE:    state_d = DRAIN;
      DRAIN:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/enable logic; grant is masked while reset is held.
  always_comb begin
    req_ready = '0;
    load_in   = 1'b0;
    load_out  = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          req_ready[grant_idx] = rst_n;
          load_in              = 1'b1;
        end
      end
      CODE:    load_out = 1'b1;
      DRAIN:   done     = out_ready;
      default: ;
    endcase
  end

  // Datapath: capture, encode register, and completion bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q  <= '0;
      ch_q      <= '0;
      ptr_q     <= CH_W'(N_CH - 1);
      out_valid <= 1'b0;
      out_alaw  <= '0;
      out_ch    <= '0;
      conv_cnt  <= '0;
    end else begin
      if (load_in) begin
        sample_q <= req_sample[32'(grant_idx)*SAMPLE_W +: SAMPLE_W];
        ch_q     <= grant_idx;
      end
      if (load_out) begin
        out_alaw  <= alaw_c;
        out_ch    <= ch_q;
        out_valid <= 1'b1;
      end
      if (done) begin
        out_valid <= 1'b0;
        ptr_q     <= ch_q;
        conv_cnt  <= conv_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/alaw_encode_arbiter.md
# alaw_encode_arbiter

Shares one combinational A-law encoder between `N_CH` linear-PCM requesters. It uses round-robin arbitration and a valid/ready handshake on both sides. Each granted 13-bit sign-magnitude sample is captured, encoded and presented on a registered output, tagged with its channel index, until the downstream sink accepts it. The block sits between the per-channel sample sources and the shared A-law output stream.

## Interface
Parameters:
- `N_CH`, 4: number of requesters; must be ≥2.
- `CH_W`, 2: channel index width; must equal $clog2(N_CH).
- `CNT_W`, 16: width of the completed-conversion counter.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_CH  per-channel sample valid.
- `req_sample`  in  13*N_CH  channel i occupies bits [13i+12:13i]. Bit 12 is the sign; bits 11:0 are the magnitude.
- `req_ready`  out  N_CH  one-hot grant/accept; combinational.
- `out_valid`  out  1  encoded byte valid.
- `out_ready`  in  1  sink accepts the byte.
- `out_alaw`  out  8  encoded byte: {sign, 3-bit segment, 4-bit mantissa}.
- `out_ch`  out  CH_W  channel index that produced `out_alaw`.
- `conv_cnt`  out  CNT_W  number of completed output handshakes.

## Operation
The FSM has three states: IDLE, CODE and DRAIN.

- **IDLE**
  - If any `req_valid` is set, grant the first set channel, searching upward from `ptr+1` mod N_CH.
  - Drive `req_ready[g]`=1 combinationally in that same cycle. Only one bit is ever set.
  - Latch `req_sample[g]` into `sample_q` and `g` into `ch_q`, then go to CODE.
  - If no `req_valid` is set, stay in IDLE with `req_ready`=0.
- **CODE**
  - Register the encoder result of `sample_q` into `out_alaw`, and `ch_q` into `out_ch`.
  - Set `out_valid`=1 and go to DRAIN.
- **DRAIN**
  - Hold `out_valid`, `out_alaw` and `out_ch` stable while `out_ready`=0.
  - On `out_valid`&&`out_ready`:
    - clear `out_valid`;
    - set `ptr`<=`ch_q`;
    - increment `conv_cnt` (wraps modulo 2^CNT_W);
    - go to IDLE.
- `req_ready` is 0 in CODE and DRAIN.
- Requester contract: once `req_valid` is raised, hold it and keep `req_sample` stable until `req_ready` is seen. The block does not check this.
- Encoding rule:
  - The sign bit passes through unchanged.
  - The segment is the position of the leading 1 in magnitude bits 11:5. Segment 0 applies when bits 11:5 are 0; bits 11:5 = 1 also gives segment 1.
  - Mantissa bits by segment:
    - segments 0 and 1: bits 4:1;
    - segment 2: bits 5:2;
    - segment 3: bits 6:3;
    - segment 4: bits 7:4;
    - segment 5: bits 8:5;
    - segment 6: bits 9:6;
    - segment 7: bits 10:7.
- `ptr` is updated only on output completion. This keeps the arbitration fair even under backpressure.

## Timing
- Reset values:
  - state=IDLE;
  - `ptr`=N_CH-1, so channel 0 has first priority;
  - `out_valid`=0, `out_alaw`=8'h00, `out_ch`=0, `conv_cnt`=0;
  - `req_ready`=0 while `rst_n`=0.
- Latency: an input handshake in cycle T gives `out_valid`=1 from cycle T+2.
- Throughput: with `out_ready` tied high, the block completes one sample every 3 cycles.
- Simultaneous requests: exactly one channel is granted per IDLE visit; the others wait with `req_valid` held.
- Wrap-around: the priority search wraps from N_CH-1 to 0. `conv_cnt` wraps from 2^CNT_W-1 to 0.
- Reset mid-operation:
  - Asserting `rst_n` in any state immediately forces the reset values.
  - An in-flight sample is discarded and is not counted.
- Deassertion of `rst_n` must be synchronised externally to `clk`.

## Structure
- Shared package `alaw_pkg` holds:
  - `SAMPLE_W`=13 and `ALAW_W`=8;
  - the FSM state enum `arb_state_t` {IDLE, CODE, DRAIN};
  - the encode function, or its constants.
- One natural sub-module is the existing combinational A-law encoder `alaw_coder`. It is instantiated once, driven by `sample_q`, and its output is registered in CODE.
- The round-robin grant logic stays inline, as a priority search over `req_valid` rotated by `ptr+1`.

## Test plan
- Reset: hold `rst_n`=0 with random inputs -> all outputs are 0 and `req_ready`=0. After release, the first grant goes to ch0 when all channels are valid.
- Single positive sample: ch0 `req_sample`=13'h0FFF, `out_ready`=1 -> `req_ready[0]` at T, then `out_alaw`=8'h7F and `out_ch`=0 at T+2, then `conv_cnt`=1.
- Negative small sample: ch2 `req_sample`=13'h1021 -> `out_alaw`=8'h90 and `out_ch`=2. Also 13'h0000 -> 8'h00.
- Fairness: all 4 channels are held valid continuously with `out_ready`=1 -> the grant order is 0,1,2,3,0,1, with one grant every 3 cycles.
- Backpressure: `out_ready`=0 for 5 cycles during DRAIN -> `out_alaw` and `out_ch` are stable, `req_ready`=0 throughout, and the handshake completes on the first cycle `out_ready`=1.
- Mid-operation reset: assert `rst_n`=0 while in CODE -> `out_valid`=0 and `conv_cnt`=0 immediately. After release, with all channels valid, ch0 is granted first.
